// File: rtl/ram_arbiter.sv
// Multi-channel front-end for a single-port synchronous RAM macro.
// Arbitrates requesters, extends sub-word loads and performs sub-word stores as read-modify-write.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned RR     = 1
) (
    input  logic                     ram_clk,
    input  logic                     ram_rst,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_wen,
    input  logic [2*NUM_CH-1:0]      ch_size,
    input  logic [NUM_CH-1:0]        ch_unsigned,
    input  logic [32*NUM_CH-1:0]     ch_addr,
    input  logic [32*NUM_CH-1:0]     ch_wdata,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [32*NUM_CH-1:0]     ch_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     mem_wen,
    input  logic [31:0]              mem_rdata
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;

    logic [CH_W-1:0]      r_grant;
    logic [CH_W-1:0]      r_last_grant;
    logic                 r_wen;
    logic                 r_uns;
    logic [1:0]           r_size;
    logic [1:0]           r_lane;
    logic [31:0]          r_wdata;

    logic [NUM_CH-1:0]    r_ch_ready;
    logic [NUM_CH-1:0]    r_ch_err;
    logic [32*NUM_CH-1:0] r_ch_rdata;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic                 r_mem_wen;

    logic                 w_gnt_found;
    logic [CH_W-1:0]      w_gnt_idx;
    int unsigned          w_idx;
    logic [NUM_CH-1:0]    w_req_sh;

    logic [31:0]          w_s_addr;
    logic [31:0]          w_s_wdata;
    logic [1:0]           w_s_size;
    logic                 w_s_wen;
    logic                 w_s_uns;
    logic                 w_s_illegal;

    logic [4:0]           w_shamt;
    logic [31:0]          w_lane;
    logic [31:0]          w_load_val;
    logic [31:0]          w_mask;
    logic [31:0]          w_merged;

    logic                 w_latch;
    logic                 w_load_we;
    logic                 w_done;
    logic [CH_W-1:0]      w_done_ch;
    logic                 w_done_err;
    logic [NUM_CH-1:0]    w_ready_nxt;
    logic [NUM_CH-1:0]    w_err_nxt;
    logic [ADDR_W-1:0]    w_mem_addr_nxt;
    logic [31:0]          w_mem_wdata_nxt;
    logic                 w_mem_wen_nxt;

    assign ch_ready  = r_ch_ready;
    assign ch_err    = r_ch_err;
    assign ch_rdata  = r_ch_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wen   = r_mem_wen;

    // Grant search: rotating from last_grant+1 under RR, lowest index otherwise
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_idx       = 0;
        w_req_sh    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (RR != 0) begin
                w_idx = (32'(r_last_grant) + i + 32'd1) % NUM_CH;
            end else begin
                w_idx = i;
            end
            w_req_sh = ch_req >> w_idx;
            if (!w_gnt_found && w_req_sh[0]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = CH_W'(w_idx);
            end
        end
    end

    assign w_s_addr  = 32'(ch_addr  >> (32'(w_gnt_idx) * 32'd32));
    assign w_s_wdata = 32'(ch_wdata >> (32'(w_gnt_idx) * 32'd32));
    assign w_s_size  = 2'(ch_size   >> (32'(w_gnt_idx) * 32'd2));
    assign w_s_wen   = 1'(ch_wen      >> 32'(w_gnt_idx));
    assign w_s_uns   = 1'(ch_unsigned >> 32'(w_gnt_idx));

    assign w_s_illegal = (w_s_size == 2'd3)
                      || ((w_s_size == 2'd1) && w_s_addr[0])
                      || ((w_s_size == 2'd2) && (w_s_addr[1:0] != 2'b00))
                      || ((w_s_addr >> (ADDR_W + 2)) != 32'd0);

    // Lane extraction for loads and lane merge for sub-word stores
    assign w_shamt  = {r_lane, 3'b000};
    assign w_lane   = mem_rdata >> w_shamt;
    assign w_mask   = ((r_size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
    assign w_merged = (mem_rdata & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

    always_comb begin
        w_load_val = mem_rdata;
        case (r_size)
            2'd0:    w_load_val = r_uns ? {24'd0, w_lane[7:0]}  : {{24{w_lane[7]}}, w_lane[7:0]};
            2'd1:    w_load_val = r_uns ? {16'd0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
            default: w_load_val = mem_rdata;
        endcase
    end

    // Next state and next values of the registered outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_latch         = 1'b0;
        w_load_we       = 1'b0;
        w_done          = 1'b0;
        w_done_ch       = r_grant;
        w_done_err      = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wen_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_found) begin
                    w_latch = 1'b1;
                    if (w_s_illegal) begin
                        w_state_nxt = S_DONE;
                        w_done      = 1'b1;
                        w_done_ch   = w_gnt_idx;
                        w_done_err  = 1'b1;
                    end else begin
                        w_state_nxt    = S_ISSUE;
                        w_mem_addr_nxt = w_s_addr[ADDR_W+1:2];
                        if (w_s_wen && (w_s_size == 2'd2)) begin
                            w_mem_wen_nxt   = 1'b1;
                            w_mem_wdata_nxt = w_s_wdata;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (r_wen && (r_size == 2'd2)) begin
                    w_state_nxt = S_DONE;
                    w_done      = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!r_wen) begin
                    w_load_we   = 1'b1;
                    w_state_nxt = S_DONE;
                    w_done      = 1'b1;
                end else begin
                    w_mem_wdata_nxt = w_merged;
                    w_mem_wen_nxt   = 1'b1;
                    w_state_nxt     = S_WB;
                end
            end
            S_WB: begin
                w_state_nxt = S_DONE;
                w_done      = 1'b1;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready_nxt = '0;
        w_err_nxt   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_ready_nxt[c] = w_done && (CH_W'(c) == w_done_ch);
            w_err_nxt[c]   = w_done && w_done_err && (CH_W'(c) == w_done_ch);
        end
    end

    always_ff @(posedge ram_clk or posedge ram_rst) begin
        if (ram_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ram_clk or posedge ram_rst) begin
        if (ram_rst) begin
            r_grant      <= '0;
            r_last_grant <= CH_W'(NUM_CH - 1);
            r_wen        <= 1'b0;
            r_uns        <= 1'b0;
            r_size       <= 2'd0;
            r_lane       <= 2'd0;
            r_wdata      <= 32'd0;
            r_ch_ready   <= '0;
            r_ch_err     <= '0;
            r_ch_rdata   <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
            r_mem_wen    <= 1'b0;
        end else begin
            r_ch_ready  <= w_ready_nxt;
            r_ch_err    <= w_err_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wen   <= w_mem_wen_nxt;
            if (w_latch) begin
                r_grant <= w_gnt_idx;
                r_wen   <= w_s_wen;
                r_uns   <= w_s_uns;
                r_size  <= w_s_size;
                r_lane  <= w_s_addr[1:0];
                r_wdata <= w_s_wdata;
            end
            if (r_state == S_DONE) begin
                r_last_grant <= r_grant;
            end
            if (w_load_we) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (CH_W'(c) == r_grant) begin
                        r_ch_rdata[32*c +: 32] <= w_load_val;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: RR instance with a RAM model, plus a fixed-priority instance.
module tb_ram_arbiter;

    localparam int unsigned ADDR_W = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Round-robin instance
    logic [1:0]  ch_req = '0, ch_wen = '0, ch_uns = '0;
    logic [3:0]  ch_size = '0;
    logic [63:0] ch_addr = '0, ch_wdata = '0;
    logic [1:0]  ch_ready, ch_err;
    logic [63:0] ch_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_wen;
    logic [31:0] ram [0:(1<<ADDR_W)-1];

    ram_arbiter #(.ADDR_W(ADDR_W), .NUM_CH(2), .RR(1)) dut (
        .ram_clk(clk), .ram_rst(rst),
        .ch_req(ch_req), .ch_wen(ch_wen), .ch_size(ch_size), .ch_unsigned(ch_uns),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_ready(ch_ready), .ch_err(ch_err), .ch_rdata(ch_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Fixed-priority instance: word loads only, macro returns the word address
    logic [1:0]  fp_req = '0;
    logic [1:0]  fp_ready, fp_err;
    logic [63:0] fp_rdata;
    logic [ADDR_W-1:0] fp_mem_addr;
    logic [31:0] fp_mem_wdata, fp_mem_rdata;
    logic        fp_mem_wen;

    ram_arbiter #(.ADDR_W(ADDR_W), .NUM_CH(2), .RR(0)) dut_fp (
        .ram_clk(clk), .ram_rst(rst),
        .ch_req(fp_req), .ch_wen(2'b00), .ch_size(4'b1010), .ch_unsigned(2'b00),
        .ch_addr({32'h0000_0020, 32'h0000_0010}), .ch_wdata(64'd0),
        .ch_ready(fp_ready), .ch_err(fp_err), .ch_rdata(fp_rdata),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wen(fp_mem_wen), .mem_rdata(fp_mem_rdata)
    );

    always @(posedge clk) fp_mem_rdata <= {18'd0, fp_mem_addr};

    typedef struct {
        int          ch;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          start;
        int          nwen;
        logic [31:0] waddr;
    } sb_item_t;

    sb_item_t    sb[$];
    int          fp_q[$];
    logic [31:0] last_rd [2];
    int          wen_cnt = 0;
    logic [31:0] last_waddr = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Completion monitor for the RR instance
    always @(negedge clk) begin
        sb_item_t it;
        if (rst) begin
            wen_cnt = 0;
        end else begin
            if (mem_wen) begin
                wen_cnt++;
                last_waddr = 32'(mem_addr);
            end
            if (|ch_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_ready", 32'(ch_ready), 32'd0);
                end else begin
                    it = sb.pop_front();
                    check_eq("ready_vec", 32'(ch_ready), 32'(1 << it.ch));
                    check_eq("err_vec", 32'(ch_err), it.err ? 32'(1 << it.ch) : 32'd0);
                    check_eq("rdata", 32'(ch_rdata >> (32 * it.ch)), it.rdata);
                    check_eq("wen_pulses", 32'(wen_cnt), 32'(it.nwen));
                    if (it.lat >= 0) check_eq("latency", 32'(cyc - it.start), 32'(it.lat));
                    if (it.nwen > 0) check_eq("wen_addr", last_waddr, it.waddr);
                end
                wen_cnt = 0;
            end
        end
    end

    // Completion monitor for the fixed-priority instance
    always @(negedge clk) begin
        int e;
        if (!rst && (|fp_ready)) begin
            if (fp_q.size() == 0) begin
                check_eq("fp_unexpected_ready", 32'(fp_ready), 32'd0);
            end else begin
                e = fp_q.pop_front();
                check_eq("fp_grant", 32'(fp_ready), 32'(1 << e));
                check_eq("fp_err", 32'(fp_err), 32'd0);
                check_eq("fp_rdata", 32'(fp_rdata >> (32 * e)), (e == 0) ? 32'd4 : 32'd8);
                check_eq("fp_mem_w", {fp_mem_wdata[31:1], fp_mem_wdata[0] | fp_mem_wen}, 32'd0);
            end
        end
    end

    // Drive one request on a channel, queue its expectation, hold until ready
    task automatic do_req(input int ch, input logic wen, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic err, input logic [31:0] exp_rd);
        sb_item_t it;
        bit got = 1'b0;
        if (!wen && !err) last_rd[ch] = exp_rd;
        it.ch    = ch;
        it.err   = err;
        it.rdata = last_rd[ch];
        it.start = cyc;
        it.waddr = {18'd0, addr[ADDR_W+1:2]};
        if (err)              begin it.lat = 1; it.nwen = 0; end
        else if (!wen)        begin it.lat = 3; it.nwen = 0; end
        else if (size == 2'd2) begin it.lat = 2; it.nwen = 1; end
        else                  begin it.lat = 4; it.nwen = 1; end
        sb.push_back(it);
        ch_wen[ch]            = wen;
        ch_size[2*ch +: 2]    = size;
        ch_uns[ch]            = uns;
        ch_addr[32*ch +: 32]  = addr;
        ch_wdata[32*ch +: 32] = wdata;
        ch_req[ch]            = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ch_ready[ch]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_eq("req_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        ch_req[ch] = 1'b0;
    endtask

    localparam logic [31:0] VAL_A = 32'hCAFE_F00D;
    localparam logic [31:0] VAL_B = 32'h0BAD_C0DE;

    initial begin
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(ch_ready), 32'd0);
        check_eq("rst_err", 32'(ch_err), 32'd0);
        check_eq("rst_rdata_lo", ch_rdata[31:0], 32'd0);
        check_eq("rst_rdata_hi", ch_rdata[63:32], 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_mem_wen", 32'(mem_wen), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word store then load
        do_req(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'd0);
        do_req(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b0, 32'hDEAD_BEEF);

        // Sub-word read-modify-write
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h80, 32'h1122_3344, 1'b0, 32'd0);
        do_req(0, 1'b1, 2'd0, 1'b0, 32'h82, 32'h1234_56AA, 1'b0, 32'd0);
        do_req(0, 1'b1, 2'd1, 1'b0, 32'h80, 32'hFFFF_BEEF, 1'b0, 32'd0);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 1'b0, 32'h11AA_BEEF);

        // Load extension
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF_7F01, 1'b0, 32'd0);
        do_req(0, 1'b0, 2'd0, 1'b0, 32'h102, 32'd0, 1'b0, 32'hFFFF_FFFF);
        do_req(0, 1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 1'b0, 32'h0000_0080);
        do_req(0, 1'b0, 2'd1, 1'b0, 32'h100, 32'd0, 1'b0, 32'h0000_7F01);
        do_req(0, 1'b0, 2'd1, 1'b0, 32'h102, 32'd0, 1'b0, 32'hFFFF_80FF);
        do_req(1, 1'b0, 2'd1, 1'b1, 32'h102, 32'd0, 1'b0, 32'h0000_80FF);

        // Preload for arbitration and reset tests
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h140, VAL_A, 1'b0, 32'd0);
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h144, VAL_B, 1'b0, 32'd0);

        // Illegal requests on ch1 (last grant ends on ch1)
        do_req(1, 1'b0, 2'd2, 1'b0, 32'h42, 32'd0, 1'b1, 32'd0);
        do_req(1, 1'b1, 2'd1, 1'b0, 32'h81, 32'h1234, 1'b1, 32'd0);
        do_req(1, 1'b0, 2'd3, 1'b0, 32'h0, 32'd0, 1'b1, 32'd0);
        do_req(1, 1'b0, 2'd2, 1'b0, 32'(1 << (ADDR_W + 2)), 32'd0, 1'b1, 32'd0);

        // Round-robin: both channels requesting continuously
        begin
            sb_item_t it;
            for (int k = 0; k < 4; k++) begin
                it.ch    = k % 2;
                it.err   = 1'b0;
                it.rdata = (k % 2 == 0) ? VAL_A : VAL_B;
                it.lat   = -1;
                it.start = 0;
                it.nwen  = 0;
                it.waddr = '0;
                sb.push_back(it);
            end
            last_rd[0] = VAL_A;
            last_rd[1] = VAL_B;
            ch_wen   = 2'b00;
            ch_size  = 4'b1010;
            ch_uns   = 2'b00;
            ch_addr  = {32'h144, 32'h140};
            ch_req   = 2'b11;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                if (sb.size() == 0) break;
            end
            check_eq("rr_drain", 32'(sb.size()), 32'd0);
            #1;
            ch_req = 2'b00;
        end

        // Fixed priority: ch0 wins until it drops
        fp_q.push_back(0);
        fp_q.push_back(0);
        fp_q.push_back(0);
        fp_req = 2'b11;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            if (fp_q.size() == 0) break;
        end
        check_eq("fp_drain0", 32'(fp_q.size()), 32'd0);
        #1;
        fp_q.push_back(1);
        fp_req[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            if (fp_q.size() == 0) break;
        end
        check_eq("fp_drain1", 32'(fp_q.size()), 32'd0);
        #1;
        fp_req = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted during the write-back of a byte store
        ch_wen[0]       = 1'b1;
        ch_size[1:0]    = 2'd0;
        ch_uns[0]       = 1'b0;
        ch_addr[31:0]   = 32'h141;
        ch_wdata[31:0]  = 32'h55;
        ch_req[0]       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("wb_wen_before_rst", 32'(mem_wen), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst_mem_wen", 32'(mem_wen), 32'd0);
        check_eq("arst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("arst_mem_wdata", mem_wdata, 32'd0);
        check_eq("arst_ready", 32'(ch_ready), 32'd0);
        check_eq("arst_rdata_lo", ch_rdata[31:0], 32'd0);
        check_eq("arst_rdata_hi", ch_rdata[63:32], 32'd0);
        ch_req[0]  = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h140, 32'd0, 1'b0, VAL_A);
        do_req(1, 1'b0, 2'd0, 1'b1, 32'h141, 32'd0, 1'b0, 32'h0000_00F0);

        repeat (3) @(posedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
